// File: rtl/riscv_alu_tag_pipe_if.sv
// Handshake and data bundle for the DIFT tag ALU.
// slave is the ALU view; master is the producer/consumer view.
interface riscv_alu_tag_pipe_if #(
   parameter int TAG_WIDTH  = 4,
   parameter int MODE_WIDTH = 2,
   parameter int CNT_WIDTH  = 8
);
   logic                  valid_i;
   logic                  ready_o;
   logic [MODE_WIDTH-1:0] operator_i;
   logic [TAG_WIDTH-1:0]  operand_a_i;
   logic [TAG_WIDTH-1:0]  operand_b_i;
   logic                  check_en_i;
   logic [TAG_WIDTH-1:0]  check_mask_i;
   logic                  valid_o;
   logic                  ready_i;
   logic [TAG_WIDTH-1:0]  result_o;
   logic                  rf_enable_tag_o;
   logic                  pc_enable_tag_o;
   logic                  exception_o;
   logic                  trap_o;
   logic                  trap_clear_i;
   logic [CNT_WIDTH-1:0]  viol_count_o;

   modport slave (
      input  valid_i, operator_i, operand_a_i, operand_b_i,
      input  check_en_i, check_mask_i, ready_i, trap_clear_i,
      output ready_o, valid_o, result_o, rf_enable_tag_o,
      output pc_enable_tag_o, exception_o, trap_o, viol_count_o
   );

   modport master (
      output valid_i, operator_i, operand_a_i, operand_b_i,
      output check_en_i, check_mask_i, ready_i, trap_clear_i,
      input  ready_o, valid_o, result_o, rf_enable_tag_o,
      input  pc_enable_tag_o, exception_o, trap_o, viol_count_o
   );
endinterface

// File: rtl/riscv_alu_tag_pipe.sv
// DIFT tag ALU: one registered stage, policy check,
// trap FSM and saturating violation counter.
module riscv_alu_tag_pipe #(
   parameter int TAG_WIDTH  = 4,
   parameter int MODE_WIDTH = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   riscv_alu_tag_pipe_if.slave bus
);
   typedef enum logic {RUN, TRAP} state_e;

   state_e                state_q, state_d;
   logic [TAG_WIDTH-1:0]  res_d, res_q;
   logic                  en_d, en_q;
   logic                  exc_q, valid_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  is_and, is_or, is_clr;
   logic                  ready, accept, viol;

   assign is_and = bus.operator_i == MODE_WIDTH'(1);
   assign is_or  = bus.operator_i == MODE_WIDTH'(2);
   assign is_clr = bus.operator_i == MODE_WIDTH'(3);

   always_comb begin
      res_d = '0;
      en_d  = 1'b0;
      unique case (1'b1)
         is_and: begin
            res_d = bus.operand_a_i & bus.operand_b_i;
            en_d  = 1'b1;
         end
         is_or: begin
            res_d = bus.operand_a_i | bus.operand_b_i;
            en_d  = 1'b1;
         end
         is_clr: en_d = 1'b1;
         default: ;
      endcase
   end

   // en_d doubles as "mode is not OLD"
   assign viol   = bus.check_en_i && en_d &&
                   (|(res_d & bus.check_mask_i));
   assign ready  = (state_q == RUN) &&
                   (!valid_q || bus.ready_i);
   assign accept = bus.valid_i && ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (accept && viol) state_d = TRAP;
         TRAP:    if (bus.trap_clear_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         res_q   <= '0;
         en_q    <= 1'b0;
         exc_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
            en_q    <= en_d;
            exc_q   <= viol;
         end else if (bus.ready_i) begin
            valid_q <= 1'b0;
         end
         if (accept && viol && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.ready_o         = ready;
   assign bus.valid_o         = valid_q;
   assign bus.result_o        = res_q;
   assign bus.rf_enable_tag_o = valid_q && en_q;
   assign bus.pc_enable_tag_o = valid_q && en_q;
   assign bus.exception_o     = valid_q && exc_q;
   assign bus.trap_o          = (state_q == TRAP);
   assign bus.viol_count_o    = cnt_q;
endmodule
